// File: rtl/seq_mult_shift_add.sv
// seq_mult_shift_add
//   Sequential shift-add multiplier. One multiplier bit is consumed per
//   clock. Signed operands are converted to magnitudes on acceptance.
//   The sign of the result is reapplied when the result is written.
//
// Parameters:
//   WIDTH  operand width (>= 2); the product is 2*WIDTH bits wide.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset; aborts any operation
//   start  request; sampled only while busy is low
//   sgn    1 = signed two's complement, 0 = unsigned (sampled with start)
//   mcd    multiplicand (sampled with start)
//   mlt    multiplier (sampled with start)
//   busy   high from the accept edge until the result edge
//   done   one-cycle pulse when prod is updated
//   prod   registered product, held until the next result
module seq_mult_shift_add #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sgn,
  input  logic [WIDTH-1:0]   mcd,
  input  logic [WIDTH-1:0]   mlt,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t             state_reg, state_next;
  logic [WIDTH:0]     acc_reg, acc_next;
  logic [WIDTH-1:0]   shreg_reg, shreg_next;
  logic [WIDTH-1:0]   mcd_mag_reg, mcd_mag_next;
  logic               neg_reg, neg_next;
  logic [CW-1:0]      count_reg, count_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic [2*WIDTH-1:0] prod_reg, prod_next;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      acc_reg     <= '0;
      shreg_reg   <= '0;
      mcd_mag_reg <= '0;
      neg_reg     <= 1'b0;
      count_reg   <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      prod_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      acc_reg     <= acc_next;
      shreg_reg   <= shreg_next;
      mcd_mag_reg <= mcd_mag_next;
      neg_reg     <= neg_next;
      count_reg   <= count_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      prod_reg    <= prod_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    acc_next     = acc_reg;
    shreg_next   = shreg_reg;
    mcd_mag_next = mcd_mag_reg;
    neg_next     = neg_reg;
    count_next   = count_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    prod_next    = prod_reg;
    sum          = '0;
    raw          = '0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          // In signed mode the operands become magnitudes. -2^(W-1) negates
          // to the same bit pattern, and that pattern read as unsigned is
          // the correct magnitude.
          neg_next     = sgn & (mcd[WIDTH-1] ^ mlt[WIDTH-1]);
          mcd_mag_next = (sgn && mcd[WIDTH-1]) ? -mcd : mcd;
          shreg_next   = (sgn && mlt[WIDTH-1]) ? -mlt : mlt;
          acc_next     = '0;
          count_next   = '0;
          busy_next    = 1'b1;
          state_next   = RUN;
        end
      end

      RUN: begin
        sum = acc_reg + {1'b0, (shreg_reg[0] ? mcd_mag_reg : {WIDTH{1'b0}})};
        // Shift the accumulator and the multiplier right together as one
        // wide register. The product bits fill shreg from the top.
        {acc_next, shreg_next} = {sum, shreg_reg} >> 1;
        count_next = count_reg + CW'(1);
        if (count_reg == CW'(WIDTH - 1)) begin
          state_next = FINISH;
        end
      end

      FINISH: begin
        raw        = {acc_reg[WIDTH-1:0], shreg_reg};
        prod_next  = neg_reg ? -raw : raw;
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign prod = prod_reg;

endmodule

// File: tb/tb_seq_mult_shift_add.sv
// Testbench for seq_mult_shift_add (WIDTH=8 and WIDTH=4 instances).
// Inputs are driven and outputs are sampled on the falling clock edge.
// Expected products are pushed to a queue when start is driven.
// They are popped when done is seen.
module tb_seq_mult_shift_add;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start8, sgn8, busy8, done8;
  logic [7:0]  mcd8, mlt8;
  logic [15:0] prod8;
  logic        start4, sgn4, busy4, done4;
  logic [3:0]  mcd4, mlt4;
  logic [7:0]  prod4;

  seq_mult_shift_add #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sgn(sgn8), .mcd(mcd8), .mlt(mlt8),
    .busy(busy8), .done(done8), .prod(prod8)
  );

  seq_mult_shift_add #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .sgn(sgn4), .mcd(mcd4), .mlt(mlt4),
    .busy(busy4), .done(done4), .prod(prod4)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] q8[$];
  logic [7:0]  q4[$];

  function automatic logic [15:0] ref8(input logic s, input logic [7:0] a, input logic [7:0] b);
    logic signed [31:0] x, y, r;
    x = s ? {{24{a[7]}}, a} : {24'b0, a};
    y = s ? {{24{b[7]}}, b} : {24'b0, b};
    r = x * y;
    return r[15:0];
  endfunction

  function automatic logic [7:0] ref4(input logic s, input logic [3:0] a, input logic [3:0] b);
    logic signed [31:0] x, y, r;
    x = s ? {{28{a[3]}}, a} : {28'b0, a};
    y = s ? {{28{b[3]}}, b} : {28'b0, b};
    r = x * y;
    return r[7:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue8(input logic s, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    start8 = 1'b1; sgn8 = s; mcd8 = a; mlt8 = b;
    q8.push_back(ref8(s, a, b));
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic issue4(input logic s, input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    start4 = 1'b1; sgn4 = s; mcd4 = a; mlt4 = b;
    q4.push_back(ref4(s, a, b));
    @(negedge clk);
    start4 = 1'b0;
  endtask

  // Called one falling edge after the accept edge. It waits for done and
  // scores the product. Optionally it checks latency, busy length and that
  // prod held hold_val while waiting.
  task automatic wait8(input string tag, input bit chk_lat, input bit chk_hold,
                       input logic [15:0] hold_val);
    int cyc, busy_cyc;
    bit held;
    logic [15:0] e;
    cyc = 1; busy_cyc = 0; held = 1'b1;
    while (!done8 && cyc < 40) begin
      if (busy8) busy_cyc++;
      if (prod8 !== hold_val) held = 1'b0;
      @(negedge clk);
      cyc++;
    end
    if (!done8) begin
      chk({tag, " done timeout"}, {31'b0, done8}, 32'd1);
    end else if (q8.size() == 0) begin
      chk({tag, " scoreboard empty"}, q8.size(), 32'd1);
    end else begin
      e = q8.pop_front();
      $display("w8 %s: prod=%h exp=%h cycles=%0d", tag, prod8, e, cyc);
      chk(tag, {16'b0, prod8}, {16'b0, e});
      if (chk_lat) begin
        chk({tag, " latency"}, cyc, 32'd10);
        chk({tag, " busy cycles"}, busy_cyc, 32'd9);
        chk({tag, " busy low at done"}, {31'b0, busy8}, 32'd0);
      end
      if (chk_hold) chk({tag, " prod held"}, {31'b0, held}, 32'd1);
    end
  endtask

  task automatic wait4(input string tag, input bit chk_lat);
    int cyc, busy_cyc;
    logic [7:0] e;
    cyc = 1; busy_cyc = 0;
    while (!done4 && cyc < 30) begin
      if (busy4) busy_cyc++;
      @(negedge clk);
      cyc++;
    end
    if (!done4) begin
      chk({tag, " done timeout"}, {31'b0, done4}, 32'd1);
    end else if (q4.size() == 0) begin
      chk({tag, " scoreboard empty"}, q4.size(), 32'd1);
    end else begin
      e = q4.pop_front();
      $display("w4 %s: prod=%h exp=%h cycles=%0d", tag, prod4, e, cyc);
      chk(tag, {24'b0, prod4}, {24'b0, e});
      if (chk_lat) begin
        chk({tag, " latency"}, cyc, 32'd6);
        chk({tag, " busy cycles"}, busy_cyc, 32'd5);
      end
    end
  endtask

  function automatic logic [7:0] pick8();
    case ($urandom_range(0, 5))
      0: return 8'h00;
      1: return 8'h01;
      2: return 8'hFF;
      3: return 8'h80;
      4: return 8'h7F;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    start8 = 1'b0; sgn8 = 1'b0; mcd8 = '0; mlt8 = '0;
    start4 = 1'b0; sgn4 = 1'b0; mcd4 = '0; mlt4 = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset busy", {31'b0, busy8}, 32'd0);
    chk("reset done", {31'b0, done8}, 32'd0);
    chk("reset prod", {16'b0, prod8}, 32'd0);
    chk("reset prod w4", {24'b0, prod4}, 32'd0);
    rst = 1'b0;

    // Unsigned max x max, with latency and one-cycle done.
    issue8(1'b0, 8'hFF, 8'hFF);
    chk("busy after accept", {31'b0, busy8}, 32'd1);
    wait8("u 255x255", 1'b1, 1'b1, 16'h0000);
    @(negedge clk);
    chk("done one cycle", {31'b0, done8}, 32'd0);
    chk("prod held after done", {16'b0, prod8}, 32'h0000FE01);

    // Signed cases.
    issue8(1'b1, 8'hFD, 8'h05);
    wait8("s -3x5", 1'b1, 1'b0, 16'h0);
    issue8(1'b1, 8'h80, 8'h80);
    wait8("s -128x-128", 1'b0, 1'b0, 16'h0);
    issue8(1'b1, 8'h7F, 8'h80);
    wait8("s 127x-128", 1'b0, 1'b0, 16'h0);
    issue8(1'b1, 8'h00, 8'hFF);
    wait8("s 0x-1", 1'b0, 1'b0, 16'h0);

    // A start while busy must be ignored.
    issue8(1'b0, 8'd10, 8'd20);
    start8 = 1'b1; sgn8 = 1'b1; mcd8 = 8'd99; mlt8 = 8'd77;
    repeat (3) @(negedge clk);
    start8 = 1'b0;
    wait8("start during busy ignored", 1'b0, 1'b0, 16'h0);

    // A start in the done cycle is accepted, and prod holds meanwhile.
    issue8(1'b0, 8'hFF, 8'hFF);
    wait8("u 255x255 again", 1'b0, 1'b0, 16'h0);
    start8 = 1'b1; sgn8 = 1'b0; mcd8 = 8'd12; mlt8 = 8'd10;
    q8.push_back(ref8(1'b0, 8'd12, 8'd10));
    @(negedge clk);
    start8 = 1'b0;
    wait8("start in done cycle 12x10", 1'b1, 1'b1, 16'hFE01);

    // Reset at step 4 aborts the operation asynchronously.
    issue8(1'b0, 8'd200, 8'd3);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort busy", {31'b0, busy8}, 32'd0);
    chk("abort done", {31'b0, done8}, 32'd0);
    chk("abort prod", {16'b0, prod8}, 32'd0);
    q8.delete();
    @(negedge clk);
    rst = 1'b0;
    issue8(1'b0, 8'd7, 8'd6);
    wait8("after abort 7x6", 1'b1, 1'b0, 16'h0);

    // WIDTH=4 instance.
    issue4(1'b0, 4'hF, 4'hF);
    wait4("w4 u 15x15", 1'b1);
    issue4(1'b1, 4'h8, 4'h7);
    wait4("w4 s -8x7", 1'b0);

    // Random operands from both modes, biased toward edge values.
    for (int i = 0; i < 1000; i++) begin
      logic s;
      logic [7:0] a, b;
      s = 1'($urandom);
      a = pick8();
      b = pick8();
      issue8(s, a, b);
      wait8($sformatf("rnd%0d s=%0d %h*%h", i, s, a, b), 1'b0, 1'b0, 16'h0);
    end
    for (int i = 0; i < 100; i++) begin
      logic s;
      logic [3:0] a, b;
      s = 1'($urandom);
      a = 4'($urandom);
      b = 4'($urandom);
      issue4(s, a, b);
      wait4($sformatf("w4 rnd%0d s=%0d %h*%h", i, s, a, b), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_mult_shift_add.md
Name: seq_mult_shift_add

Overview:
Parametrised sequential shift-add multiplier with a start/busy/done handshake and a runtime-selectable signed (two's complement) or unsigned mode. One partial-product bit is processed per clock, which keeps area small for the datapath slices of the design. It is the generalised successor of the fixed 8x8 unsigned multiplier. Unlike that block, it holds its result stable, runs only on request, and reports completion.

Parameters:
WIDTH, 8, operand width in bits (>= 2); product is 2*WIDTH bits.

Ports:
clk  input  1  clock, rising-edge active.
rst  input  1  reset, asynchronous, active-high.
start  input  1  request; sampled only while busy=0.
sgn  input  1  mode, sampled with start: 1 = signed two's complement, 0 = unsigned.
mcd  input  WIDTH  multiplicand, sampled with start.
mlt  input  WIDTH  multiplier, sampled with start.
busy  output  1  high from the accept edge until the result edge.
done  output  1  one-cycle pulse; prod is valid while done=1 and afterwards.
prod  output  2*WIDTH  registered product; held until the next result.

Behaviour:
- Reset (rst=1, async): state=IDLE; busy=0, done=0, prod=0; counter and accumulator cleared. Reset mid-operation aborts the operation; no done pulse is produced.
- FSM states: IDLE, RUN, FINISH.
- IDLE: start=1 at a rising edge (accept edge E0) latches sgn and the operand magnitudes.
  - Signed mode: |x| is used; the negative-result flag is sign(mcd) XOR sign(mlt).
  - Unsigned mode: raw operands are used; the flag is 0.
  - On E0: acc(WIDTH+1 bits)=0, multiplier shift register=|mlt|, count=0, busy=1, state=RUN.
- RUN: each edge performs one step.
  - If the shift register LSB is 1, acc += |mcd| (WIDTH+1-bit add, no overflow possible).
  - {acc, shreg} is then shifted right by 1 as a 2*WIDTH+1-bit value.
  - count increments. After step WIDTH (edge E_WIDTH), state=FINISH.
- FINISH: on edge E_WIDTH+1:
  - prod = raw product {acc, shreg}[2*WIDTH-1:0], two's-complement negated if the flag is set;
  - done=1, busy=0, state=IDLE.
- done is high for exactly the one cycle following E_WIDTH+1, then returns to 0. Start-to-done latency is WIDTH+2 rising edges including the accept edge.
- start while busy=1 is ignored; operands and sgn may change freely during RUN/FINISH without effect.
- start=1 in the done cycle (state IDLE) is accepted. Back-to-back throughput is one result per WIDTH+2 cycles.
- start held high continuously produces repeated operations, each re-sampling the inputs.
- Arithmetic range: signed -2^(W-1) x -2^(W-1) = +2^(2W-2) fits in 2*WIDTH bits. The magnitude 2^(W-1) fits in the WIDTH-bit unsigned path. Negation of a zero product yields 0.
- prod changes only on the result edge or on reset.

Test Plan:
- WIDTH=8, unsigned 255x255, start pulsed 1 cycle -> busy=1 for 9 cycles, done pulses on the 10th cycle after accept, prod=0xFE01.
- WIDTH=8, signed: -3x5 -> prod=0xFFF1 (-15); -128x-128 -> prod=0x4000; 127x-128 -> prod=0xC080; 0x-1 -> prod=0x0000.
- Handshake: start asserted during busy with different operands -> ignored, result matches the first operands. start in the done cycle with 12x10 unsigned -> accepted, second done 10 cycles later, prod=0x0078. prod holds its previous value (0xFE01) until then.
- Reset mid-operation: rst asserted at step 4 of 200x3 -> busy=0, done=0, prod=0 immediately (asynchronous). A new start after release computes 7x6=0x002A correctly.
- WIDTH=4, unsigned 15x15 -> prod=0xE1 after 6 edges; signed -8x7 -> prod=0xC8 (-56).
- Randomised check: 1000 random operand/sgn pairs against a reference model, covering both modes and operand edge values 0, 1, max, and min-signed.
